hazard_stall_ctrl: RTL

- Pipeline sequencing controller that drives the stall and flush controls of the IF/ID and ID/IX pipeline registers and the PC.
- Detects load-use hazards between ID and IX and inserts a programmable number of bubbles into ID/IX.
- Squashes wrong-path instructions for a programmable number of cycles when IX resolves a taken branch or jump.
- Sits beside the decode stage. Its outputs are Mealy and settle in the first half-cycle so the negedge-latched pipeline registers sample them in the same cycle.

---
 rtl/hazard_stall_ctrl_if.sv | 37 +++
 rtl/hazard_stall_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the decode/execute pipeline and hazard_stall_ctrl.
// The pipeline side is the master; the controller is the slave.
interface hazard_stall_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ix_is_load;
  logic        ix_write_to_reg;
  logic [4:0]  ix_dest;
  logic        ix_branch_taken;
  logic        ix_is_jump;

  logic        pc_stall;
  logic        ifid_stall;
  logic        idix_stall;
  logic        ifid_flush;
  logic        idix_flush;
  logic        pc_redirect;
  logic [1:0]  ctrl_state;
  logic [31:0] perf_stalls;
  logic [31:0] perf_flushes;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
           ix_is_load, ix_write_to_reg, ix_dest, ix_branch_taken, ix_is_jump,
    input  pc_stall, ifid_stall, idix_stall, ifid_flush, idix_flush,
           pc_redirect, ctrl_state, perf_stalls, perf_flushes
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
           ix_is_load, ix_write_to_reg, ix_dest, ix_branch_taken, ix_is_jump,
    output pc_stall, ifid_stall, idix_stall, ifid_flush, idix_flush,
           pc_redirect, ctrl_state, perf_stalls, perf_flushes
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall and branch/jump flush sequencer with Mealy outputs.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned REDIRECT_CYCLES   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_REDIR  = 2'd2
  } state_e;

  localparam logic [3:0] LOAD_RELOAD  = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] REDIR_RELOAD = 4'(REDIRECT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic rs_hit, rt_hit, hz, rd;
  logic pc_stall, ifid_stall, idix_stall;
  logic ifid_flush, idix_flush, pc_redirect;

  assign rs_hit = bus.id_uses_rs && (bus.id_rs == bus.ix_dest);
  assign rt_hit = bus.id_uses_rt && (bus.id_rt == bus.ix_dest);
  // $0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hz     = bus.ix_is_load && bus.ix_write_to_reg && (bus.ix_dest != 5'd0)
                  && (rs_hit || rt_hit);
  assign rd     = bus.ix_branch_taken || bus.ix_is_jump;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idix_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idix_flush  = 1'b0;
    pc_redirect = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (rd) begin
          pc_redirect = 1'b1;
          ifid_flush  = 1'b1;
          idix_flush  = 1'b1;
          if (REDIRECT_CYCLES > 1) begin
            state_d = ST_REDIR;
            cnt_d   = REDIR_RELOAD;
          end
        end else if (hz) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idix_stall = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = ST_LSTALL;
            cnt_d   = LOAD_RELOAD;
          end
        end
      end

      ST_LSTALL: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idix_stall = 1'b1;
        cnt_d      = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RUN;
      end

      ST_REDIR: begin
        ifid_flush = 1'b1;
        idix_flush = 1'b1;
        cnt_d      = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase

    // Reset clears the pipeline combinationally, overriding any sequence in flight.
    if (!rst_n) begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idix_stall  = 1'b0;
      ifid_flush  = 1'b1;
      idix_flush  = 1'b1;
      pc_redirect = 1'b0;
    end
  end

  // NOTE: reset is synchronous and state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_stall    = pc_stall;
  assign bus.ifid_stall  = ifid_stall;
  assign bus.idix_stall  = idix_stall;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idix_flush  = idix_flush;
  assign bus.pc_redirect = pc_redirect;
  assign bus.ctrl_state  = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stalls_q, perf_flushes_q;

  // Flushes forced by reset are not counted: the counters clear instead.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stalls_q  <= 32'd0;
      perf_flushes_q <= 32'd0;
    end else begin
      if (idix_stall) perf_stalls_q  <= perf_stalls_q + 32'd1;
      if (idix_flush) perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign bus.perf_stalls  = perf_stalls_q;
  assign bus.perf_flushes = perf_flushes_q;
`else
  assign bus.perf_stalls  = 32'd0;
  assign bus.perf_flushes = 32'd0;
`endif

endmodule
